// File: rtl/pong_game_ctrl_pkg.sv
// Shared definitions for the Pong game sequencer: match states, default
// parameter values and a helper that sizes the serve counter.
package pong_game_ctrl_pkg;

    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } state_e;

    localparam int DEF_WIN_SCORE          = 10;
    localparam int DEF_SCORE_W            = 4;
    localparam int DEF_SERVE_DELAY_FRAMES = 60;

    // Width needed to hold 0..n, never less than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the ball/paddle logic (master) and the game
// sequencer (slave). The pause level exists only when PONG_PAUSE_EN is defined.
interface pong_game_ctrl_if #(parameter int SCORE_W = 4);

    logic               start;
    logic               frame_tick;
    logic               p1_miss;
    logic               p2_miss;
`ifdef PONG_PAUSE_EN
    logic               pause;
`endif
    logic [1:0]         state;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic               ball_run;
    logic               ball_reset;
    logic               serve_dir;
    logic               p1_win;
    logic               p2_win;

    modport master (
`ifdef PONG_PAUSE_EN
        output pause,
`endif
        output start, frame_tick, p1_miss, p2_miss,
        input  state, p1_score, p2_score, ball_run, ball_reset,
        input  serve_dir, p1_win, p2_win
    );

    modport slave (
`ifdef PONG_PAUSE_EN
        input  pause,
`endif
        input  start, frame_tick, p1_miss, p2_miss,
        output state, p1_score, p2_score, ball_run, ball_reset,
        output serve_dir, p1_win, p2_win
    );

endinterface

// File: rtl/pong_serve_timer.sv
// Loadable frame down-counter used to park the ball before a serve.
// Load wins over tick; the count stops at zero and reports it via zero_o.
module pong_serve_timer #(
    parameter int CNT_W    = 1,
    parameter int LOAD_VAL = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic tick_i,
    output logic zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload on serve-hold entry, otherwise count ticks down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(LOAD_VAL);
        end else if (tick_i && (cnt_q != {CNT_W{1'b0}})) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: state machine, scores, serve timing and ball
// run/recentre controls. All outputs are registered.
// Optional feature macro: PONG_PAUSE_EN adds a pause level on the interface.
module pong_game_ctrl
    import pong_game_ctrl_pkg::*;
#(
    parameter int WIN_SCORE          = DEF_WIN_SCORE,
    parameter int SCORE_W            = DEF_SCORE_W,
    parameter int SERVE_DELAY_FRAMES = DEF_SERVE_DELAY_FRAMES
) (
    input  logic           clk,
    input  logic           reset,
    pong_game_ctrl_if.slave bus
);

    localparam int                 CNT_W   = cnt_width(SERVE_DELAY_FRAMES);
    localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] p1_q, p1_d;
    logic [SCORE_W-1:0] p2_q, p2_d;
    logic               dir_q, dir_d;
    logic               run_q, run_d;
    logic               brst_q, brst_d;
    logic               w1_q, w1_d;
    logic               w2_q, w2_d;
    logic               pause_s;
    logic               entering_s;
    logic               timer_tick_s;
    logic               timer_zero_s;

`ifdef PONG_PAUSE_EN
    assign pause_s = bus.pause;
`else
    assign pause_s = 1'b0;
`endif

    pong_serve_timer #(
        .CNT_W    (CNT_W),
        .LOAD_VAL (SERVE_DELAY_FRAMES)
    ) u_serve_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (entering_s),
        .tick_i (timer_tick_s),
        .zero_o (timer_zero_s)
    );

    // Match state transitions and score/serve bookkeeping.
    always_comb begin
        state_d = state_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        dir_d   = dir_q;
        case (state_q)
            QI: begin
                p1_d = {SCORE_W{1'b0}};
                p2_d = {SCORE_W{1'b0}};
                if (bus.start) begin
                    state_d = QGAME_1;
                    dir_d   = 1'b1;
                end else begin
                    state_d = QI;
                end
            end
            QGAME_1: begin
                if (!bus.start) begin
                    state_d = QI;
                    p1_d    = {SCORE_W{1'b0}};
                    p2_d    = {SCORE_W{1'b0}};
                end else if (bus.frame_tick && !pause_s && timer_zero_s) begin
                    state_d = QGAME_2;
                end else begin
                    state_d = QGAME_1;
                end
            end
            QGAME_2: begin
                if (!bus.start) begin
                    state_d = QI;
                    p1_d    = {SCORE_W{1'b0}};
                    p2_d    = {SCORE_W{1'b0}};
                end else if (pause_s) begin
                    state_d = QGAME_2;
                end else if (bus.p1_miss && bus.p2_miss) begin
                    // Both edges missed at once: replay the point.
                    state_d = QGAME_1;
                end else if (bus.p2_miss) begin
                    p1_d    = p1_q + SCORE_W'(1);
                    dir_d   = 1'b1;
                    state_d = (p1_d == WIN_VAL) ? QDONE : QGAME_1;
                end else if (bus.p1_miss) begin
                    p2_d    = p2_q + SCORE_W'(1);
                    dir_d   = 1'b0;
                    state_d = (p2_d == WIN_VAL) ? QDONE : QGAME_1;
                end else begin
                    state_d = QGAME_2;
                end
            end
            QDONE: begin
                if (!bus.start) begin
                    state_d = QI;
                    p1_d    = {SCORE_W{1'b0}};
                    p2_d    = {SCORE_W{1'b0}};
                end else begin
                    state_d = QDONE;
                end
            end
            default: begin
                state_d = QI;
                p1_d    = {SCORE_W{1'b0}};
                p2_d    = {SCORE_W{1'b0}};
            end
        endcase
    end

    // Output values derived from the next state so they switch with it.
    always_comb begin
        entering_s   = (state_d == QGAME_1) && (state_q != QGAME_1);
        timer_tick_s = (state_q == QGAME_1) && bus.frame_tick && !pause_s;
        run_d        = (state_d == QGAME_2) && !pause_s;
        brst_d       = entering_s;
        w1_d         = (state_d == QDONE) && (p1_d == WIN_VAL);
        w2_d         = (state_d == QDONE) && (p2_d == WIN_VAL);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= QI;
            p1_q    <= {SCORE_W{1'b0}};
            p2_q    <= {SCORE_W{1'b0}};
            dir_q   <= 1'b0;
            run_q   <= 1'b0;
            brst_q  <= 1'b0;
            w1_q    <= 1'b0;
            w2_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            dir_q   <= dir_d;
            run_q   <= run_d;
            brst_q  <= brst_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.p1_score   = p1_q;
    assign bus.p2_score   = p2_q;
    assign bus.serve_dir  = dir_q;
    assign bus.ball_run   = run_q;
    assign bus.ball_reset = brst_q;
    assign bus.p1_win     = w1_q;
    assign bus.p2_win     = w2_q;

endmodule
